// File: rtl/video_pkg.sv
// Shared definitions for the video pattern generator: pattern modes and
// controller state encoding.
package video_pkg;

   typedef enum logic [1:0] {
      MODE_RAMP  = 2'd0,
      MODE_BARS  = 2'd1,
      MODE_CHECK = 2'd2,
      MODE_CONST = 2'd3
   } mode_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/vtg_counter.sv
// Horizontal/vertical raster counter. Advances only while run is high and
// flags the last clock of each frame.
module vtg_counter #(
   parameter int H_TOTAL = 1440,
   parameter int V_TOTAL = 600,
   localparam int HW = $clog2(H_TOTAL),
   localparam int VW = $clog2(V_TOTAL)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   output logic [HW-1:0] h_cnt,
   output logic [VW-1:0] v_cnt,
   output logic          frame_wrap
);

   logic h_last;
   logic v_last;

   assign h_last     = (h_cnt == HW'(H_TOTAL - 1));
   assign v_last     = (v_cnt == VW'(V_TOTAL - 1));
   assign frame_wrap = run && h_last && v_last;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, and the async reset sits in the sensitivity list.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (run) begin
         if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
         end else begin
            h_cnt <= h_cnt + HW'(1);
         end
      end
   end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: ramp, colour bars, checkerboard or constant,
// with registered vsync/dvalid/sof timing and a completed-frame counter.
module video_pattern_gen
   import video_pkg::*;
#(
   parameter int IW      = 640,
   parameter int IH      = 512,
   parameter int DW      = 8,
   parameter int NCH     = 1,
   parameter int H_TOTAL = 1440,
   parameter int V_TOTAL = 600,
   parameter int VS_B    = 5,
   parameter int VS_E    = 55,
   parameter int VLD_B   = 65,
   parameter int CK      = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [NCH*DW-1:0] const_val,
   output logic              vsync,
   output logic              dvalid,
   output logic [NCH*DW-1:0] data,
   output logic              sof,
   output logic [15:0]       frame_cnt
);

   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);

   if ((IW % 8 != 0) || (IW >= H_TOTAL) || (VLD_B + IH > V_TOTAL) || (VS_E >= VLD_B)) begin : g_bad_params
      $error("video_pattern_gen: illegal timing parameter combination");
   end

   state_t            state_q, state_d;
   logic              run;
   logic [HW-1:0]     h_cnt;
   logic [VW-1:0]     v_cnt;
   logic              frame_wrap;
   mode_t             mode_q;
   logic [NCH*DW-1:0] const_q;

   logic [31:0]       x, y;
   logic              active, vs_active, chk;
   logic [DW-1:0]     ramp;
   logic [2:0]        bar_rgb;
   logic [NCH*DW-1:0] pix;

   vtg_counter #(
      .H_TOTAL (H_TOTAL),
      .V_TOTAL (V_TOTAL)
   ) u_vtg_counter (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .h_cnt      (h_cnt),
      .v_cnt      (v_cnt),
      .frame_wrap (frame_wrap)
   );

   assign run = (state_q == ST_RUN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: every signal driven here gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (en) state_d = ST_RUN;
         ST_RUN:  if (frame_wrap && !en) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Pixel coordinates; y wraps negative outside the active window, where data is masked.
   assign x         = 32'(h_cnt);
   assign y         = 32'(v_cnt) - 32'(VLD_B);
   assign active    = (x < 32'(IW)) && (32'(v_cnt) >= 32'(VLD_B)) && (32'(v_cnt) < 32'(VLD_B + IH));
   assign vs_active = (32'(v_cnt) >= 32'(VS_B)) && (32'(v_cnt) <= 32'(VS_E));
   assign ramp      = DW'(x + y);
   assign bar_rgb   = 3'(32'd7 - x / 32'(IW / 8));
   assign chk       = x[CK] ^ y[CK];

   always_comb begin
      pix = '0;
      for (int c = 0; c < NCH; c++) begin
         case (mode_q)
            MODE_RAMP:  pix[c*DW +: DW] = ramp;
            MODE_BARS:  pix[c*DW +: DW] = ((bar_rgb >> (c % 3)) & 3'b001) != 3'b000 ? '1 : '0;
            MODE_CHECK: pix[c*DW +: DW] = chk ? '1 : '0;
            default:    pix[c*DW +: DW] = const_q[c*DW +: DW];
         endcase
      end
   end

   // Pattern selection is latched once per frame so a frame is never mixed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q  <= MODE_RAMP;
         const_q <= '0;
      end else if (run && (h_cnt == '0) && (v_cnt == '0)) begin
         mode_q  <= mode_t'(mode);
         const_q <= const_val;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vsync  <= 1'b1;
         dvalid <= 1'b0;
         data   <= '0;
         sof    <= 1'b0;
      end else if (run) begin
         vsync  <= !vs_active;
         dvalid <= active;
         data   <= active ? pix : '0;
         sof    <= active && (h_cnt == '0) && (v_cnt == VW'(VLD_B));
      end else begin
         vsync  <= 1'b1;
         dvalid <= 1'b0;
         data   <= '0;
         sof    <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)           frame_cnt <= '0;
      else if (frame_wrap) frame_cnt <= frame_cnt + 16'd1;
   end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen: frame-position reference model,
// directed pattern spot checks and randomized mode/const changes.
module tb_video_pattern_gen;

   localparam int IW = 8, IH = 4, H_TOTAL = 12, V_TOTAL = 8;
   localparam int VS_B = 1, VS_E = 2, VLD_B = 3, DW = 8, NCH = 3, CK = 1;
   localparam int FRAME = H_TOTAL * V_TOTAL;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [23:0] const_val = 24'h0;
   logic        vsync, dvalid, sof;
   logic [23:0] data;
   logic [15:0] frame_cnt;

   always #5 clk = ~clk;

   video_pattern_gen #(
      .IW(IW), .IH(IH), .DW(DW), .NCH(NCH), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
      .VS_B(VS_B), .VS_E(VS_E), .VLD_B(VLD_B), .CK(CK)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .mode      (mode),
      .const_val (const_val),
      .vsync     (vsync),
      .dvalid    (dvalid),
      .data      (data),
      .sof       (sof),
      .frame_cnt (frame_cnt)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: running flag, flat position within the frame, frame count, latched pattern.
   bit          m_run = 1'b0;
   int          m_pos = 0;
   int          m_fcnt = 0;
   int          m_mode = 0;
   logic [23:0] m_const = 24'h0;

   int          t_dv, t_vs, t_sof;
   logic [23:0] grid [IH][IW];
   int          fc_start;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [23:0] model_pixel(input int px, input int py, input int md, input logic [23:0] cv);
      logic [23:0] p;
      int b;
      p = 24'h0;
      case (md)
         0: for (int c = 0; c < NCH; c++) p[c*8 +: 8] = 8'((px + py) % 256);
         1: begin
            b = px / (IW / 8);
            for (int c = 0; c < NCH; c++)
               if ((((7 - b) >> (c % 3)) & 1) != 0) p[c*8 +: 8] = 8'hFF;
         end
         2: if ((((px >> CK) ^ (py >> CK)) & 1) != 0) p = 24'hFFFFFF;
         default: p = cv;
      endcase
      return p;
   endfunction

   task automatic clear_tally();
      t_dv = 0; t_vs = 0; t_sof = 0;
   endtask

   // One clock: predict outputs from the pre-edge model, advance the model, then compare.
   task automatic step();
      logic        e_vs, e_dv, e_sof;
      logic [23:0] e_data;
      int          h, v, px, py;
      h      = m_pos % H_TOTAL;
      v      = m_pos / H_TOTAL;
      px     = h;
      py     = v - VLD_B;
      e_vs   = !(m_run && v >= VS_B && v <= VS_E);
      e_dv   = m_run && h < IW && v >= VLD_B && v < VLD_B + IH;
      e_data = e_dv ? model_pixel(px, py, m_mode, m_const) : 24'h0;
      e_sof  = e_dv && px == 0 && py == 0;
      @(posedge clk);
      if (m_run) begin
         if (m_pos == 0) begin
            m_mode  = int'(mode);
            m_const = const_val;
         end
         if (m_pos == FRAME - 1) begin
            m_fcnt = (m_fcnt + 1) % 65536;
            if (!en) m_run = 1'b0;
         end
         m_pos = (m_pos + 1) % FRAME;
      end else if (en) begin
         m_run = 1'b1;
         m_pos = 0;
      end
      #1;
      check("vsync", 32'(vsync), 32'(e_vs));
      check("dvalid", 32'(dvalid), 32'(e_dv));
      check("data", 32'(data), 32'(e_data));
      check("sof", 32'(sof), 32'(e_sof));
      check("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
      if (dvalid) t_dv++;
      if (!vsync) t_vs++;
      if (sof) t_sof++;
      if (e_dv) grid[py][px] = data;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Assert reset between edges and check the outputs clear without waiting for a clock.
   task automatic pulse_reset();
      #2 reset = 1'b1;
      #1;
      check("rst_dvalid", 32'(dvalid), 32'd0);
      check("rst_vsync", 32'(vsync), 32'd1);
      check("rst_fcnt", 32'(frame_cnt), 32'd0);
      check("rst_data", 32'(data), 32'd0);
      check("rst_sof", 32'(sof), 32'd0);
      m_run = 1'b0; m_pos = 0; m_fcnt = 0; m_mode = 0; m_const = 24'h0;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("init_vsync", 32'(vsync), 32'd1);
      check("init_dvalid", 32'(dvalid), 32'd0);
      check("init_data", 32'(data), 32'd0);
      check("init_sof", 32'(sof), 32'd0);
      check("init_fcnt", 32'(frame_cnt), 32'd0);
      reset = 1'b0;
      run(3);

      // Ramp frame
      en = 1'b1; mode = 2'd0;
      step();
      clear_tally(); run(FRAME);
      check("ramp_dv_cycles", 32'(t_dv), 32'(IH * IW));
      check("ramp_vs_low", 32'(t_vs), 32'((VS_E - VS_B + 1) * H_TOTAL));
      check("ramp_sof_count", 32'(t_sof), 32'd1);
      check("ramp_y1_x3", 32'(grid[1][3]), 32'h040404);
      check("ramp_y3_x7", 32'(grid[3][7]), 32'h0a0a0a);

      // Colour bars
      mode = 2'd1;
      clear_tally(); run(FRAME);
      check("bars_px0", 32'(grid[0][0]), 32'hFFFFFF);
      check("bars_px7", 32'(grid[0][7]), 32'h000000);
      check("bars_px1", 32'(grid[0][1]), 32'hFFFF00);

      // Checkerboard
      mode = 2'd2;
      clear_tally(); run(FRAME);
      check("chk_l0_p0", 32'(grid[0][0]), 32'h000000);
      check("chk_l0_p1", 32'(grid[0][1]), 32'h000000);
      check("chk_l0_p2", 32'(grid[0][2]), 32'hFFFFFF);
      check("chk_l0_p3", 32'(grid[0][3]), 32'hFFFFFF);
      check("chk_l2_p0", 32'(grid[2][0]), 32'hFFFFFF);
      check("chk_l2_p2", 32'(grid[2][2]), 32'h000000);

      // Mid-frame switch to constant takes effect only on the next frame
      mode = 2'd0;
      clear_tally(); run(50);
      mode = 2'd3; const_val = 24'h123456;
      run(FRAME - 50);
      check("sw_cur_y3_x0", 32'(grid[3][0]), 32'h030303);
      check("sw_cur_y3_x7", 32'(grid[3][7]), 32'h0a0a0a);
      clear_tally(); run(FRAME);
      check("sw_next_y0_x0", 32'(grid[0][0]), 32'h123456);
      check("sw_next_y3_x7", 32'(grid[3][7]), 32'h123456);
      check("sw_next_dv", 32'(t_dv), 32'(IH * IW));

      // Randomized mode/const changes at arbitrary points
      for (int i = 0; i < 6 * FRAME; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            mode      = 2'($urandom_range(0, 3));
            const_val = 24'($urandom);
         end
         step();
      end

      // Drop en at v_cnt=4: frame completes, then idle
      fc_start = m_fcnt;
      run(4 * H_TOTAL);
      en = 1'b0;
      run(FRAME - 4 * H_TOTAL);
      check("drop_fcnt", 32'(frame_cnt), 32'((fc_start + 1) % 65536));
      clear_tally(); run(20);
      check("idle_dv", 32'(t_dv), 32'd0);
      check("idle_vs_low", 32'(t_vs), 32'd0);
      check("idle_sof", 32'(t_sof), 32'd0);
      check("idle_fcnt", 32'(frame_cnt), 32'((fc_start + 1) % 65536));

      // Reset in the middle of an active line, then restart from 0,0
      en = 1'b1; mode = 2'd0;
      step();
      run(40);
      check("pre_rst_dvalid", 32'(dvalid), 32'd1);
      pulse_reset();
      step();
      clear_tally(); run(FRAME);
      check("restart_sof", 32'(t_sof), 32'd1);
      check("restart_dv", 32'(t_dv), 32'(IH * IW));
      check("restart_fcnt", 32'(frame_cnt), 32'd1);
      check("restart_y2_x5", 32'(grid[2][5]), 32'h070707);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have parameter IW, default 640, active pixels per line.
REQ-002 SHALL have parameter IH, default 512, active lines per frame.
REQ-003 SHALL have parameter DW, default 8, bits per channel.
REQ-004 SHALL have parameter NCH, default 1, channels per pixel (1..4).
REQ-005 SHALL have parameters H_TOTAL, default 1440, and V_TOTAL, default 600, giving clocks per line and lines per frame.
REQ-006 SHALL have parameters VS_B, default 5, and VS_E, default 55, giving the first and last vsync line, inclusive.
REQ-007 SHALL have parameter VLD_B, default 65, first active line; CK, default 3, log2 checker square size.
REQ-008 SHALL have port clk, input, 1, sole clock, all logic rising-edge.
REQ-009 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port en, input, 1, run request.
REQ-011 SHALL have port mode, input, 2, pattern select: 0 ramp, 1 colour bars, 2 checker, 3 constant.
REQ-012 SHALL have port const_val, input, NCH*DW, mode-3 pixel value, channel 0 in LSBs.
REQ-013 SHALL have port vsync, output, 1, active-low frame sync.
REQ-014 SHALL have port dvalid, output, 1, pixel valid.
REQ-015 SHALL have port data, output, NCH*DW, pixel data.
REQ-016 SHALL have port sof, output, 1, one-cycle pulse coincident with the first dvalid of each frame.
REQ-017 SHALL have port frame_cnt, output, 16, count of completed frames.

Function
REQ-018 SHALL keep h_cnt running 0..H_TOTAL-1; at H_TOTAL-1 it wraps to 0 and v_cnt advances, wrapping 0 after V_TOTAL-1.
REQ-019 SHALL register all outputs, one cycle latency from counter state.
REQ-020 SHALL drive vsync low exactly when VS_B <= v_cnt <= VS_E; high otherwise.
REQ-021 SHALL drive dvalid high exactly when h_cnt < IW and VLD_B <= v_cnt < VLD_B+IH, giving IW consecutive cycles per active line.
REQ-022 SHALL use x = h_cnt and y = v_cnt - VLD_B as pixel coordinates.
REQ-023 SHALL make mode 0 output every channel = (x + y) mod 2^DW.
REQ-024 SHALL make mode 1 use bar b = x / (IW/8) and give channel c all-ones if bit (c mod 3) of (7-b) is 1, else zero.
REQ-025 SHALL make mode 2 give all channels all-ones when ((x>>CK) xor (y>>CK)) bit 0 = 1, else zero.
REQ-026 SHALL make mode 3 output const_val.
REQ-027 SHALL force data to zero whenever dvalid is low.
REQ-028 SHALL sample mode and const_val only at frame start (h_cnt=0, v_cnt=0); mid-frame changes take effect next frame.
REQ-029 SHALL use two states: IDLE (counters held 0, vsync high, dvalid/data/sof 0) and RUN.
REQ-030 SHALL transition IDLE->RUN on the first cycle en=1; counting starts at 0,0.
REQ-031 SHALL evaluate en at the RUN frame wrap: en=0 -> IDLE, never truncating a frame mid-way.
REQ-032 SHALL increment frame_cnt at each frame wrap in RUN, wrapping 65535->0.
REQ-033 SHALL reject at elaboration: IW%8!=0, IW>=H_TOTAL, VLD_B+IH>V_TOTAL, VS_E>=VLD_B.

Reset
REQ-034 SHALL on reset enter IDLE with counters 0, vsync 1, dvalid 0, data 0, sof 0, frame_cnt 0, sampled mode 0, sampled const 0.
REQ-035 SHALL make reset asserted mid-frame abort immediately; after release, behave as from power-up.

Structure
REQ-036 SHALL put the mode constants and the state encoding in shared package video_pkg.
REQ-037 SHALL implement h/v counting in sub-module vtg_counter (params H_TOTAL, V_TOTAL; outputs h_cnt, v_cnt, frame_wrap).

Verification
Bench params: IW=8, IH=4, H_TOTAL=12, V_TOTAL=8, VS_B=1, VS_E=2, VLD_B=3, DW=8, NCH=3, CK=1.
REQ-038 SHALL cover: en=1, mode=0 -> per frame 4 bursts of 8 dvalid cycles; line y byte k = y+k; vsync low 24 cycles; one sof per frame.
REQ-039 SHALL cover: mode=1 -> pixel 0 = 0xFFFFFF, pixel 7 = 0x000000, pixel 1 = 0xFFFF00 (channel 0 low).
REQ-040 SHALL cover: mode=2 -> line 0 pixels 0-1 zero, 2-3 all-ones; line 2 inverted.
REQ-041 SHALL cover: mode 0->3 with const_val=0x123456 mid-frame -> current frame stays ramp; next frame all pixels 0x123456.
REQ-042 SHALL cover: en dropped at v_cnt=4 -> frame completes, frame_cnt increments once, then IDLE outputs held.
REQ-043 SHALL cover: reset pulsed mid-line -> same cycle dvalid=0, vsync=1, frame_cnt=0; restart aligns to h_cnt=0, v_cnt=0.
